// File: rtl/cmos_rgb565_capture.sv
// DVP camera capture: skips start-up frames, pairs bytes into RGB565 words and
// writes them, cropped to H_ACTIVE x V_ACTIVE, into the frame-buffer write FIFO.
module cmos_rgb565_capture #(
  parameter int FRAME_SKIP = 10,
  parameter int H_ACTIVE   = 1024,
  parameter int V_ACTIVE   = 720
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  output logic        frame_valid,
  output logic        sys_we,
  output logic [15:0] sys_data_in,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        line_err
);

  typedef enum logic [1:0] {IDLE, SKIP, WAIT_SOF, ACTIVE} state_t;

  localparam logic [11:0] H_LIM = 12'(H_ACTIVE);
  localparam logic [11:0] V_LIM = 12'(V_ACTIVE);
  localparam int SKIP_W = (FRAME_SKIP > 1) ? $clog2(FRAME_SKIP) : 1;
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((FRAME_SKIP > 0) ? FRAME_SKIP - 1 : 0);

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  state_t            state;
  logic [SKIP_W-1:0] skip_cnt;
  logic              vsync_p1, href_p1;
  logic [7:0]        data_p1;
  logic              vsync_p2, href_p2, sof_p2, eof_p2;
  logic [10:0]       x, y;
  logic              phase, got_byte;
  logic [7:0]        hi;
  logic              line_end, line_bad;

  // Stage 1: pin registers; stage 2: vsync edge pulses registered once more
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_p1 <= 1'b0;
      href_p1  <= 1'b0;
      vsync_p2 <= 1'b0;
      href_p2  <= 1'b0;
      sof_p2   <= 1'b0;
      eof_p2   <= 1'b0;
    end else begin
      vsync_p1 <= cmos_vsync;
      href_p1  <= cmos_href;
      vsync_p2 <= vsync_p1;
      href_p2  <= href_p1;
      sof_p2   <= vsync_p2 & ~vsync_p1;
      eof_p2   <= ~vsync_p2 & vsync_p1;
    end
  end

  always_ff @(posedge clk) begin
    data_p1 <= cmos_data;
  end

  assign line_end = href_p2 & ~href_p1;
  assign line_bad = phase | (({1'b0, y} < V_LIM) && ({1'b0, x} < H_LIM));

  // Capture FSM, byte pairing and crop; all outputs registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      skip_cnt    <= '0;
      frame_valid <= 1'b0;
      sys_we      <= 1'b0;
      sys_data_in <= '0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      line_err    <= 1'b0;
      x           <= '0;
      y           <= '0;
      phase       <= 1'b0;
      got_byte    <= 1'b0;
      hi          <= '0;
    end else begin
      sys_we     <= 1'b0;
      frame_done <= 1'b0;
      if (!init_done) begin
        state       <= IDLE;
        frame_valid <= 1'b0;
        phase       <= 1'b0;
        got_byte    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            skip_cnt <= '0;
            state    <= (FRAME_SKIP == 0) ? WAIT_SOF : SKIP;
          end
          SKIP: begin
            if (eof_p2) begin
              if (skip_cnt == SKIP_LAST) state <= WAIT_SOF;
              else                       skip_cnt <= skip_cnt + SKIP_W'(1);
            end
          end
          WAIT_SOF: begin
            if (sof_p2) begin
              state       <= ACTIVE;
              frame_valid <= 1'b1;
              x           <= '0;
              y           <= '0;
              phase       <= 1'b0;
              got_byte    <= 1'b0;
            end
          end
          ACTIVE: begin
            if (eof_p2) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 8'd1;
            end
            // A new frame closes any line still open, then restarts geometry
            if (sof_p2) begin
              if (got_byte && line_bad) line_err <= 1'b1;
              x        <= '0;
              y        <= '0;
              phase    <= 1'b0;
              got_byte <= 1'b0;
            end else if (href_p1) begin
              got_byte <= 1'b1;
              phase    <= ~phase;
              if (!phase) begin
                hi <= data_p1;
              end else begin
                x <= sat_inc(x);
                if (({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM)) begin
                  sys_we      <= 1'b1;
                  sys_data_in <= {hi, data_p1};
                end
              end
            end else if (line_end) begin
              if (got_byte) begin
                if (line_bad) line_err <= 1'b1;
                y <= sat_inc(y);
              end
              x        <= '0;
              phase    <= 1'b0;
              got_byte <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmos_rgb565_capture.sv
// Directed bench for cmos_rgb565_capture: scoreboard of expected RGB565 words,
// frame gating, cropping, line-error and init_done handling.
module tb_cmos_rgb565_capture;

  localparam int H = 4;
  localparam int V = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic        cmos_vsync;
  logic        cmos_href;
  logic [7:0]  cmos_data;
  logic        frame_valid;
  logic        sys_we;
  logic [15:0] sys_data_in;
  logic        frame_done;
  logic [7:0]  frame_cnt;
  logic        line_err;

  cmos_rgb565_capture #(.FRAME_SKIP(2), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_data(cmos_data),
    .frame_valid(frame_valid), .sys_we(sys_we), .sys_data_in(sys_data_in),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .line_err(line_err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  int          fd_cnt = 0;
  int          m_y = 0;
  bit          m_cap = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_done === 1'b1) fd_cnt++;
    if (sys_we === 1'b1) begin
      wr_cnt++;
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("sys_data_in", 32'(sys_data_in), 32'(exp_w));
      end
    end
  endtask

  task automatic push_pix(input int pix, input logic [7:0] hb, input logic [7:0] lb);
    if (m_cap && pix < H && m_y < V) exp_q.push_back({hb, lb});
  endtask

  task automatic send_line(input int nb);
    logic [7:0] hb, b;
    hb = 8'h00;
    cmos_href = 1'b1;
    for (int i = 0; i < nb; i++) begin
      b = 8'($urandom);
      cmos_data = b;
      if (i % 2 == 0) hb = b;
      else push_pix(i / 2, hb, b);
      tick();
    end
    cmos_href = 1'b0;
    repeat (3) tick();
    if (nb > 0) m_y++;
  endtask

  task automatic frame_begin(input bit cap, input bit chk_rise);
    logic fv_early;
    m_cap = cap;
    m_y = 0;
    wr_cnt = 0;
    repeat (2) tick();
    cmos_vsync = 1'b0;
    tick();
    tick();
    fv_early = frame_valid;
    tick();
    if (chk_rise) begin
      check("fv_before_sof+2", 32'(fv_early), 32'd0);
      check("fv_at_sof+2", 32'(frame_valid), 32'd1);
    end
    tick();
  endtask

  task automatic frame_end(input int exp_wr);
    cmos_vsync = 1'b1;
    repeat (4) tick();
    check("writes_per_frame", 32'(wr_cnt), 32'(exp_wr));
  endtask

  initial begin
    rst_n = 1'b0;
    init_done = 1'b0;
    cmos_vsync = 1'b1;
    cmos_href = 1'b0;
    cmos_data = 8'h00;
    repeat (3) tick();
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_sys_we", 32'(sys_we), 32'd0);
    check("rst_sys_data_in", 32'(sys_data_in), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_line_err", 32'(line_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Three frames with init_done low: nothing may be captured
    for (int f = 0; f < 3; f++) begin
      frame_begin(1'b0, 1'b0);
      for (int l = 0; l < 3; l++) send_line(8);
      frame_end(0);
    end
    check("noinit_frame_valid", 32'(frame_valid), 32'd0);
    check("noinit_frame_cnt", 32'(frame_cnt), 32'd0);

    // Frames 1-2 skipped, 3-4 captured
    init_done = 1'b1;
    tick();
    for (int f = 1; f <= 4; f++) begin
      frame_begin(f >= 3, f == 3);
      for (int l = 0; l < 3; l++) send_line(8);
      frame_end((f >= 3) ? 8 : 0);
    end
    check("frame_cnt_after_4", 32'(frame_cnt), 32'd2);
    check("line_err_clean", 32'(line_err), 32'd0);
    check("frame_done_pulses", 32'(fd_cnt), 32'd2);

    // Frame 5: directed byte stream with latency checks
    frame_begin(1'b1, 1'b0);
    check("fv_held_active", 32'(frame_valid), 32'd1);
    cmos_href = 1'b1;
    cmos_data = 8'hA5; tick();
    cmos_data = 8'h5A; push_pix(0, 8'hA5, 8'h5A); tick();
    check("we_low_after_hi", 32'(sys_we), 32'd0);
    cmos_data = 8'h3C; tick();
    check("we_A55A", 32'(sys_we), 32'd1);
    check("data_A55A", 32'(sys_data_in), 32'h0000A55A);
    cmos_data = 8'hC3; push_pix(1, 8'h3C, 8'hC3); tick();
    check("we_one_cycle", 32'(sys_we), 32'd0);
    check("data_hold", 32'(sys_data_in), 32'h0000A55A);
    cmos_data = 8'h11; tick();
    check("we_3CC3", 32'(sys_we), 32'd1);
    check("data_3CC3", 32'(sys_data_in), 32'h00003CC3);
    cmos_data = 8'h22; push_pix(2, 8'h11, 8'h22); tick();
    cmos_data = 8'h33; tick();
    cmos_data = 8'h44; push_pix(3, 8'h33, 8'h44); tick();
    cmos_href = 1'b0;
    repeat (3) tick();
    m_y++;
    send_line(8);
    send_line(8);
    frame_end(8);

    // Frame 6: 6-pixel lines cropped to 4
    frame_begin(1'b1, 1'b0);
    for (int l = 0; l < 3; l++) send_line(12);
    frame_end(8);
    check("line_err_crop", 32'(line_err), 32'd0);

    // Frame 7: odd-length line sets the sticky error; frame 8 clean
    frame_begin(1'b1, 1'b0);
    send_line(7);
    send_line(8);
    send_line(8);
    frame_end(7);
    check("line_err_odd", 32'(line_err), 32'd1);
    frame_begin(1'b1, 1'b0);
    for (int l = 0; l < 3; l++) send_line(8);
    frame_end(8);
    check("line_err_sticky", 32'(line_err), 32'd1);

    // Frame 9: init_done dropped mid-line
    frame_begin(1'b1, 1'b0);
    cmos_href = 1'b1;
    cmos_data = 8'h12; tick();
    cmos_data = 8'h34; push_pix(0, 8'h12, 8'h34); tick();
    cmos_data = 8'h56; tick();
    cmos_data = 8'h78; init_done = 1'b0; tick();
    check("we_stop_on_deinit", 32'(sys_we), 32'd0);
    check("fv_low_on_deinit", 32'(frame_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cmos_data = 8'(i);
      tick();
    end
    cmos_href = 1'b0;
    repeat (3) tick();
    frame_end(1);

    // Re-init: skip count restarts, two frames skipped again
    init_done = 1'b1;
    tick();
    for (int f = 10; f <= 12; f++) begin
      frame_begin(f == 12, f == 12);
      for (int l = 0; l < 3; l++) send_line(8);
      frame_end((f == 12) ? 8 : 0);
    end
    check("frame_cnt_final", 32'(frame_cnt), 32'd7);
    check("frame_done_total", 32'(fd_cnt), 32'd7);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
